sync_fifo_prog: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 14 +
 rtl/sync_fifo_mem.sv | 33 +++
 rtl/sync_fifo_prog.sv | 121 ++++++++++++
 tb/tb_sync_fifo_prog.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and default parameters for the single-clock programmable FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;

  // Occupancy/pointer type for the default geometry: one extra bit so DEPTH itself is representable
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read, contents never reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem_array[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with registered status flags, programmable almost thresholds,
// live occupancy and sticky overflow/underflow error flags.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  typedef logic [ADDR_WIDTH:0] occ_t;

  occ_t wptr_reg, wptr_next;
  occ_t rptr_reg, rptr_next;
  occ_t count_next;

  logic wr_acc, rd_acc;
  logic full_reg, full_next;
  logic empty_reg, empty_next;
  logic half_reg, half_next;
  logic rd_valid_reg, rd_valid_next;
  logic overflow_reg, overflow_next;
  logic underflow_reg, underflow_next;
  logic data_zero_reg, data_zero_next;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    wr_acc         = wr_en && !full_reg;
    rd_acc         = rd_en && !empty_reg;
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    if (wr_acc) wptr_next = wptr_reg + occ_t'(1);
    if (rd_acc) rptr_next = rptr_reg + occ_t'(1);
    // Pointers wrap modulo 2*DEPTH, so their difference is the exact occupancy
    count_next     = wptr_next - rptr_next;
    full_next      = (count_next == occ_t'(DEPTH));
    empty_next     = (count_next == occ_t'(0));
    half_next      = (count_next >= occ_t'(DEPTH / 2));
    rd_valid_next  = rd_acc;
    data_zero_next = data_zero_reg && !rd_acc;
    // A new error event takes priority over a simultaneous software clear
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (wr_en && full_reg)  overflow_next  = 1'b1;
    if (rd_en && empty_reg) underflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      half_reg      <= 1'b0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      data_zero_reg <= 1'b1;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      full_reg      <= full_next;
      empty_reg     <= empty_next;
      half_reg      <= half_next;
      rd_valid_reg  <= rd_valid_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      data_zero_reg <= data_zero_next;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc && !rst),
    .waddr(wptr_reg[ADDR_WIDTH-1:0]),
    .wdata(data_in),
    .re   (rd_acc && !rst),
    .raddr(rptr_reg[ADDR_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

  // The storage read register has no reset; mask it until the first read after reset
  assign data_out     = data_zero_reg ? '0 : mem_rdata;
  assign rd_valid     = rd_valid_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign half         = half_reg;
  assign count        = wptr_reg - rptr_reg;
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog at the default 8x64 geometry.
module tb_sync_fifo_prog;
  import sync_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       half;
  ptr_t       af_thresh;
  ptr_t       ae_thresh;
  logic       almost_full;
  logic       almost_empty;
  ptr_t       count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int errors = 0;
  int checks = 0;

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .half        (half),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_seq;
    int rd_seq;
    int n;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0; clr_err = 1'b0;
    af_thresh = 7'd48; ae_thresh = 7'd4;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_half", half, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_data_out", data_out, 0);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_almost_full", almost_full, 0);
    af_thresh = 7'd0; #1;
    check("rst_af_zero", almost_full, 1);
    af_thresh = 7'd48; #1;
    $display("reset checks done");

    // Fill with 0x00..0x3F
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      step();
      wr_en = 1'b0;
      check("fill_count", count, i + 1);
      check("fill_half", half, (i + 1 >= 32) ? 1 : 0);
      check("fill_full", full, (i + 1 == 64) ? 1 : 0);
      check("fill_empty", empty, 0);
      if (i + 1 == 47) begin
        check("af_at_47", almost_full, 0);
        af_thresh = 7'd40; #1;
        check("af_thresh_40_live", almost_full, 1);
        af_thresh = 7'd48; #1;
      end
      if (i + 1 == 48) check("af_at_48", almost_full, 1);
    end
    check("fill_overflow", overflow, 0);
    $display("write: 64 words, count=%0d full=%0d", count, full);

    // Write while full
    wr_en = 1'b1; data_in = 8'hAA;
    step();
    wr_en = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 64);
    $display("write 0xAA while full: overflow=%0d", overflow);

    // Set beats clear
    wr_en = 1'b1; clr_err = 1'b1; data_in = 8'hAA;
    step();
    wr_en = 1'b0; clr_err = 1'b0;
    check("ovf_set_wins", overflow, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_cleared", overflow, 0);
    $display("clr_err: overflow=%0d", overflow);

    // Both requests while full: only the read goes through
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hAA;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("full_both_count", count, 63);
    check("full_both_ovf", overflow, 1);
    check("full_both_valid", rd_valid, 1);
    check("full_both_data", data_out, 8'h00);
    $display("both while full: data_out=0x%0h count=%0d", data_out, count);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("full_both_valid_drop", rd_valid, 0);
    check("data_hold", data_out, 8'h00);

    // Drain remaining words, alternating with idle cycles
    for (int k = 1; k < 64; k++) begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("drain_valid", rd_valid, 1);
      check("drain_data", data_out, k);
      check("drain_count", count, 63 - k);
      check("drain_ae", almost_empty, (63 - k <= 4) ? 1 : 0);
      step();
      check("drain_valid_pulse", rd_valid, 0);
      check("drain_hold", data_out, k);
    end
    check("drain_empty", empty, 1);
    check("drain_overflow", overflow, 0);
    $display("read: 63 words drained, empty=%0d", empty);

    // Read on empty
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("udf_set", underflow, 1);
    check("udf_no_valid", rd_valid, 0);
    check("udf_count", count, 0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("udf_cleared", underflow, 0);
    $display("read on empty: underflow set then cleared");

    // Both requests while empty: only the write goes through, no fall-through
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h5A;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("empty_both_count", count, 1);
    check("empty_both_udf", underflow, 1);
    check("empty_both_valid", rd_valid, 0);
    check("empty_both_empty", empty, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("empty_both_data", data_out, 8'h5A);
    check("empty_both_rd_valid", rd_valid, 1);
    check("empty_both_after", count, 0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    $display("both while empty: data_out=0x%0h", data_out);

    // Wrap-around: bursts of 40 over 300 words
    wr_seq = 0;
    rd_seq = 0;
    while (wr_seq < 300) begin
      n = (300 - wr_seq > 40) ? 40 : 300 - wr_seq;
      for (int i = 0; i < n; i++) begin
        wr_en = 1'b1; data_in = wr_seq[7:0];
        step();
        wr_seq++;
      end
      wr_en = 1'b0;
      check("wrap_burst_count", count, n);
      for (int i = 0; i < n; i++) begin
        rd_en = 1'b1;
        step();
        check("wrap_data", data_out, rd_seq & 8'hFF);
        rd_seq++;
      end
      rd_en = 1'b0;
      $display("burst: %0d words, total read=%0d", n, rd_seq);
    end
    step();
    check("wrap_count", count, 0);
    check("wrap_empty", empty, 1);
    check("wrap_errors", {30'd0, overflow, underflow}, 0);

    // Reset in the middle of a read burst
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; data_in = 8'(8'h80 + i);
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    check("mid_pre_valid", rd_valid, 1);
    check("mid_pre_data", data_out, 8'h80);
    rst = 1'b1;
    step();
    rst = 1'b0; rd_en = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_data", data_out, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("mid_rst_no_stale", rd_valid, 0);
    check("mid_rst_udf", underflow, 1);
    $display("reset mid-burst: count=%0d empty=%0d", count, empty);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
